// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction prefetch FIFO between CPU and instruction memory
// Optional hit/redirect counters are built when INST_FETCH_QUEUE_STATS_EN is defined.
module inst_fetch_queue #(
  parameter int         DEPTH   = 4,
  parameter logic [4:0] HALT_OP = 5'b00001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        cpu_i_rd,
  input  logic [7:0]  cpu_i_addr,
  output logic [15:0] i_datain,
  output logic        i_valid,
  output logic [7:0]  mem_addr,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic [15:0] perf_hits,
  output logic [15:0] perf_flushes
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state;

  logic [7:0]    addr_q  [DEPTH];
  logic [15:0]   instr_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    fetch_addr;
  // rvalid: mem_rdata this cycle answers the read issued last cycle (address in raddr)
  logic          rvalid;
  logic [7:0]    raddr;

  logic        active, start_go, fifo_empty, hit, redirect, halt_pop, push, issue;
  logic [7:0]  head_addr;
  logic [15:0] head_instr;
  logic [4:0]  occ;

  always_comb begin
    active     = (state == RUN) && enable;
    start_go   = start && enable;
    fifo_empty = (count == '0);
    head_addr  = addr_q[rd_ptr];
    head_instr = instr_q[rd_ptr];
    hit        = active && !start_go && cpu_i_rd && !fifo_empty && (head_addr == cpu_i_addr);
    redirect   = active && !start_go && cpu_i_rd &&
                 (fifo_empty ? !(rvalid || mem_re) : (head_addr != cpu_i_addr));
    halt_pop   = hit && (head_instr[15:11] == HALT_OP);
    push       = rvalid && !redirect && !start_go;
    // Both outstanding reads (arriving now and issued now) reserve a slot
    occ        = 5'(count) + 5'(rvalid) + 5'(mem_re);
    issue      = active && !start_go && !redirect && !halt_pop && (occ < 5'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_ptr]  <= raddr;
      instr_q[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= 8'h00;
      rvalid     <= 1'b0;
      raddr      <= 8'h00;
      i_datain   <= 16'h0000;
      i_valid    <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= 8'h00;
    end else if (start_go) begin
      // Restart issues address 0 right away so the first CPU request sees a read in flight
      state      <= RUN;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rvalid     <= 1'b0;
      i_valid    <= 1'b0;
      mem_re     <= 1'b1;
      mem_addr   <= 8'h00;
      fetch_addr <= 8'h01;
    end else begin
      rvalid  <= mem_re && !redirect;
      raddr   <= mem_addr;
      i_valid <= hit;
      if (hit) begin
        i_datain <= head_instr;
      end
      if (halt_pop) begin
        state <= HALTED;
      end
      if (redirect) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        mem_re     <= 1'b1;
        mem_addr   <= cpu_i_addr;
        fetch_addr <= cpu_i_addr + 8'h01;
      end else begin
        if (hit) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        count  <= count + CW'(push) - CW'(hit);
        mem_re <= issue;
        if (issue) begin
          mem_addr   <= fetch_addr;
          fetch_addr <= fetch_addr + 8'h01;
        end
      end
    end
  end

`ifdef INST_FETCH_QUEUE_STATS_EN
  logic [15:0] hit_cnt, flush_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt   <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (hit && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'h0001;
      end
      if (redirect && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'h0001;
      end
    end
  end

  assign perf_hits    = hit_cnt;
  assign perf_flushes = flush_cnt;
`else
  assign perf_hits    = 16'h0000;
  assign perf_flushes = 16'h0000;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue (DEPTH=4)
module tb_inst_fetch_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        cpu_i_rd = 1'b0;
  logic [7:0]  cpu_i_addr = 8'h00;
  logic [15:0] i_datain;
  logic        i_valid;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] perf_hits, perf_flushes;

  inst_fetch_queue dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .cpu_i_rd(cpu_i_rd), .cpu_i_addr(cpu_i_addr),
    .i_datain(i_datain), .i_valid(i_valid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .perf_hits(perf_hits), .perf_flushes(perf_flushes)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];
  logic [7:0]  last_issue = 8'h00;
  always @(posedge clock) begin
    if (mem_re) begin
      mem_rdata  <= mem[mem_addr];
      last_issue <= mem_addr;
    end
  end

  typedef struct {
    logic        en;
    logic        st;
    logic        rd;
    logic [7:0]  addr;
    logic        vld;
    logic [15:0] data;
    logic        re;
    logic [7:0]  maddr;
  } vec_t;

  vec_t        tbl [13];
  logic [15:0] exp_q [$];
  logic [7:0]  pc;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // CPU model: requests pc every cycle, advances on each delivery; expected words go to the scoreboard
  task automatic run_cpu(input int n);
    int got = 0;
    int cyc = 0;
    logic [15:0] e;
    for (int k = 0; k < n; k++) exp_q.push_back(mem[8'(pc + 8'(k))]);
    while (got < n && cyc < 200) begin
      cpu_i_rd   = 1'b1;
      cpu_i_addr = pc;
      @(negedge clock);
      cyc++;
      if (i_valid) begin
        e = exp_q.pop_front();
        check("deliver", 32'(i_datain), 32'(e));
        pc = pc + 8'h01;
        got++;
      end
    end
    if (got < n) begin
      check("deliver_timeout", 32'(got), 32'(n));
      exp_q.delete();
    end
    cpu_i_rd = 1'b0;
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    cpu_i_rd = 1'b0;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int bad;
    logic [15:0] ff0, hh0;
    logic [7:0] wexp [4];
    wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    //           en    st    rd    addr   vld   data      re    maddr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h01};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h02};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 16'h1000, 1'b1, 8'h03};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 16'h1001, 1'b1, 8'h04};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 16'h1002, 1'b1, 8'h05};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 16'h1002, 1'b1, 8'h06};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 16'h1002, 1'b0, 8'h06};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 16'h1002, 1'b0, 8'h06};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 16'h1003, 1'b0, 8'h06};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 16'h1004, 1'b1, 8'h07};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 16'h1004, 1'b0, 8'h07};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 16'h1005, 1'b1, 8'h08};

    repeat (3) @(negedge clock);
    reset = 1'b1;
    check("rst_i_valid", 32'(i_valid), 32'd0);
    check("rst_i_datain", 32'(i_datain), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // IDLE ignores the CPU
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_i_rd = 1'b1;
      cpu_i_addr = 8'h00;
      @(negedge clock);
      if (mem_re || i_valid) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en;
      start = tbl[i].st;
      cpu_i_rd = tbl[i].rd;
      cpu_i_addr = tbl[i].addr;
      @(negedge clock);
      check($sformatf("vec%0d_i_valid", i), 32'(i_valid), 32'(tbl[i].vld));
      check($sformatf("vec%0d_i_datain", i), 32'(i_datain), 32'(tbl[i].data));
      check($sformatf("vec%0d_mem_re", i), 32'(mem_re), 32'(tbl[i].re));
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
    end
    start = 1'b0;
    enable = 1'b1;
    pc = 8'h06;
    run_cpu(6);

    // Stall: FIFO fills to exactly DEPTH then reads stop
    cpu_i_rd = 1'b0;
    repeat (10) @(negedge clock);
    check("stall_mem_re", 32'(mem_re), 32'd0);
    check("stall_last_issue", 32'(last_issue), 32'(8'(pc + 8'h03)));
    run_cpu(6);

    // Redirect after delivering address 2
    pulse_start();
    pc = 8'h00;
    run_cpu(3);
    ff0 = perf_flushes;
    cpu_i_rd = 1'b1;
    cpu_i_addr = 8'h40;
    @(negedge clock);
    check("redir_mem_re", 32'(mem_re), 32'd1);
    check("redir_mem_addr", 32'(mem_addr), 32'h40);
    check("redir_i_valid", 32'(i_valid), 32'd0);
    pc = 8'h40;
    hh0 = perf_hits;
    run_cpu(3);
`ifdef INST_FETCH_QUEUE_STATS_EN
    check("perf_flushes_delta", 32'(perf_flushes - ff0), 32'd1);
    check("perf_hits_delta", 32'(perf_hits - hh0), 32'd3);
`else
    check("perf_flushes_zero", 32'(perf_flushes), 32'd0);
    check("perf_hits_zero", 32'(perf_hits), 32'd0);
`endif

    // Halt opcode at address 3
    mem[3] = 16'h0800;
    pulse_start();
    pc = 8'h00;
    run_cpu(4);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      cpu_i_rd = 1'b1;
      cpu_i_addr = pc;
      @(negedge clock);
      if (mem_re || i_valid) bad++;
    end
    check("halted_quiet", 32'(bad), 32'd0);
    mem[3] = 16'h1003;
    pulse_start();
    check("restart_mem_re", 32'(mem_re), 32'd1);
    check("restart_mem_addr", 32'(mem_addr), 32'h00);
    pc = 8'h00;
    run_cpu(3);

    // Address wrap FE, FF, 00, 01
    cpu_i_rd = 1'b1;
    cpu_i_addr = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      cpu_i_rd = 1'b0;
      check($sformatf("wrap%0d_mem_re", i), 32'(mem_re), 32'd1);
      check($sformatf("wrap%0d_mem_addr", i), 32'(mem_addr), 32'(wexp[i]));
    end
    pc = 8'hFE;
    run_cpu(4);

    // Asynchronous reset between edges
    cpu_i_rd = 1'b1;
    cpu_i_addr = pc;
    #3 reset = 1'b0;
    #1;
    check("arst_i_valid", 32'(i_valid), 32'd0);
    check("arst_i_datain", 32'(i_datain), 32'd0);
    check("arst_mem_re", 32'(mem_re), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_perf", 32'({perf_hits, perf_flushes}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cpu_i_addr = 8'(i);
      @(negedge clock);
      if (mem_re || i_valid) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have parameter HALT_OP, default 5'b00001, meaning the opcode field value that stops fetching.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  global run enable; 0 freezes fetch and delivery.
REQ-007 start  in  1  one-cycle pulse that begins fetching at address 0.
REQ-008 cpu_i_rd  in  1  CPU requests the instruction at cpu_i_addr this cycle.
REQ-009 cpu_i_addr  in  8  CPU program counter.
REQ-010 i_datain  out  16  instruction to CPU (registered).
REQ-011 i_valid  out  1  i_datain holds a valid instruction this cycle.
REQ-012 mem_addr  out  8  instruction memory address.
REQ-013 mem_re  out  1  instruction memory read strobe.
REQ-014 mem_rdata  in  16  memory data, fixed 1-cycle latency after mem_re.
REQ-015 perf_hits, perf_flushes  out  16 each  delivery and flush counters.

Function
REQ-016 States SHALL be IDLE, RUN, HALTED; start with enable=1 from any state -> RUN with fetch_addr=0 and FIFO and in-flight read flushed.
REQ-017 In RUN with enable=1, mem_re SHALL assert with mem_addr=fetch_addr when (occupancy + in-flight) < DEPTH; fetch_addr then increments, wrapping 8'hFF -> 8'h00.
REQ-018 Each FIFO entry SHALL hold {addr, instr}; returned mem_rdata SHALL be pushed one cycle after its mem_re with the issued address.
REQ-019 Hit: cpu_i_rd=1, FIFO non-empty, head addr == cpu_i_addr -> pop head; i_datain=head instr and i_valid=1 on the next cycle.
REQ-020 Miss with FIFO empty and a read in flight: i_valid=0 next cycle, no flush.
REQ-021 Redirect: cpu_i_rd=1 and (head addr != cpu_i_addr, or FIFO empty with none in flight) -> clear FIFO, discard any in-flight return, fetch_addr=cpu_i_addr, i_valid=0 next cycle.
REQ-022 A push and a pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-023 Popped instruction with bits [15:11]==HALT_OP SHALL be delivered, then state -> HALTED: no further mem_re and no further hits until start.
REQ-024 enable=0 SHALL suppress mem_re, pops and i_valid; an in-flight return SHALL still be pushed.
REQ-025 In IDLE and HALTED, mem_re=0 and i_valid=0; cpu_i_rd SHALL be ignored.
REQ-026 i_datain SHALL hold its last value when i_valid=0.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, FIFO empty, in-flight cleared, fetch_addr=0, i_datain=16'h0000, i_valid=0, mem_re=0, mem_addr=0, perf counters=0, including mid-operation.

Configuration
REQ-028 With macro INST_FETCH_QUEUE_STATS_EN defined, perf_hits SHALL count hits and perf_flushes SHALL count redirect events (start flushes excluded), saturating at 16'hFFFF.
REQ-029 Without INST_FETCH_QUEUE_STATS_EN, perf_hits and perf_flushes SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-030 Reset released, start pulse, memory word[n]=16'h1000+n, cpu_i_rd each cycle with PC 0,1,2... -> i_valid=1 with i_datain 16'h1000, 16'h1001... back-to-back once FIFO primed.
REQ-031 CPU stalls (cpu_i_rd=0) 10 cycles -> exactly DEPTH entries buffered, mem_re deasserted, no overflow; resume -> in-order delivery.
REQ-032 After delivering addr 2, cpu_i_addr=8'h40 -> FIFO flushed, in-flight return dropped, mem_addr=8'h40 next, i_datain=word[8'h40] delivered, perf_flushes=1 (STATS_EN).
REQ-033 word[3]={HALT_OP,11'b0} -> delivered with i_valid=1, then mem_re stays 0; start pulse restarts fetch at 0.
REQ-034 fetch starting at 8'hFE -> mem_addr sequence FE, FF, 00, 01.
REQ-035 reset=0 asserted mid-RUN between clock edges -> all outputs zero immediately; no mem_re until next start.
